or1k_bus_if_wbx: RTL and testbench

OR1K_BUS_IF_WBX -- requirements
Module: or1k_bus_if_wbx

---
 rtl/or1k_bus_pkg.sv | 30 +++
 rtl/or1k_wb_wrap_addr.sv | 24 ++
 rtl/or1k_bus_if_wbx.sv | 176 +++++++++++++++++
 tb/tb_or1k_bus_if_wbx.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/or1k_bus_pkg.sv
// Shared constants for the OR1K Wishbone bus interface: state encoding,
// cycle-type / burst-type codes and the burst-length to BTE mapping.
package or1k_bus_pkg;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        SINGLE     = 2'd1,
        BURST      = 2'd2,
        RETRY_WAIT = 2'd3
    } bus_state_e;

    localparam logic [2:0] CTI_CLASSIC = 3'b000;
    localparam logic [2:0] CTI_INCR    = 3'b010;
    localparam logic [2:0] CTI_EOB     = 3'b111;

    localparam logic [1:0] BTE_LINEAR = 2'b00;
    localparam logic [1:0] BTE_WRAP4  = 2'b01;
    localparam logic [1:0] BTE_WRAP8  = 2'b10;
    localparam logic [1:0] BTE_WRAP16 = 2'b11;

    function automatic logic [1:0] bte_from_len(input int len);
        case (len)
            32'd4:   return BTE_WRAP4;
            32'd8:   return BTE_WRAP8;
            32'd16:  return BTE_WRAP16;
            default: return BTE_LINEAR;
        endcase
    endfunction

endpackage

// File: rtl/or1k_wb_wrap_addr.sv
// Wrapped burst address: start address plus beat*bytes, wrapping inside the
// naturally aligned burst block, with the sub-word bits forced to zero.
module or1k_wb_wrap_addr #(
    parameter int DW           = 32,
    parameter int BURST_LENGTH = 8,
    parameter int BW           = 4
) (
    input  logic [31:0]   start_adr,
    input  logic [BW-1:0] beat,
    output logic [31:0]   adr
);
    localparam int          BYTES    = DW / 8;
    localparam int          OFF      = $clog2(BYTES);
    localparam logic [31:0] OFF_MASK = 32'(BYTES - 1);
    localparam logic [31:0] BLK_MASK = 32'(BURST_LENGTH * BYTES - 1);

    logic [31:0] step;
    logic [31:0] sum;

    assign step = 32'(beat) << OFF;
    assign sum  = start_adr + step;
    assign adr  = ((start_adr & ~BLK_MASK) | (sum & BLK_MASK)) & ~OFF_MASK;

endmodule

// File: rtl/or1k_bus_if_wbx.sv
// CPU-to-Wishbone B3 master bridge with wrapping read bursts, retry handling
// and error reporting. All wbm_* outputs are flops; CPU responses are combinational.
module or1k_bus_if_wbx
    import or1k_bus_pkg::*;
#(
    parameter int DW           = 32,
    parameter int BURST_LENGTH = 8,
    parameter int RETRY_MAX    = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_req_i,
    input  logic [31:0]       cpu_adr_i,
    input  logic [DW-1:0]     cpu_dat_i,
    input  logic [DW/8-1:0]   cpu_bsel_i,
    input  logic              cpu_we_i,
    input  logic              cpu_burst_i,
    output logic              cpu_ack_o,
    output logic              cpu_err_o,
    output logic [DW-1:0]     cpu_dat_o,
    output logic [31:0]       wbm_adr_o,
    output logic [DW-1:0]     wbm_dat_o,
    output logic [DW/8-1:0]   wbm_sel_o,
    output logic              wbm_we_o,
    output logic              wbm_cyc_o,
    output logic              wbm_stb_o,
    output logic [2:0]        wbm_cti_o,
    output logic [1:0]        wbm_bte_o,
    input  logic              wbm_ack_i,
    input  logic              wbm_err_i,
    input  logic              wbm_rty_i,
    input  logic [DW-1:0]     wbm_dat_i
);
    localparam int             BW          = $clog2(BURST_LENGTH) + 1;
    localparam int             RW          = $clog2(RETRY_MAX + 1) + 1;
    localparam logic [BW-1:0]  LAST_BEAT   = BW'(BURST_LENGTH - 1);
    localparam logic [RW-1:0]  RETRY_LIMIT = RW'(RETRY_MAX);
    localparam logic [1:0]     BURST_BTE   = bte_from_len(BURST_LENGTH);
    localparam bit             CAN_BURST   = (BURST_LENGTH > 1);

    bus_state_e     state_r, state_nxt;
    logic [BW-1:0]  beat_r, beat_nxt;
    logic [RW-1:0]  retry_r, retry_nxt;
    logic [31:0]    start_r, start_nxt;
    logic           burst_r, burst_nxt;
    logic [31:0]    adr_nxt;
    logic           cyc_nxt;
    logic [2:0]     cti_nxt;
    logic [1:0]     bte_nxt;
    logic           accept, want_burst, active;
    logic           bus_ack, bus_err, bus_rty, retry_exhausted, adr_match;

    or1k_wb_wrap_addr #(
        .DW           (DW),
        .BURST_LENGTH (BURST_LENGTH),
        .BW           (BW)
    ) u_wrap (
        .start_adr (start_nxt),
        .beat      (beat_nxt),
        .adr       (adr_nxt)
    );

    assign accept     = (state_r == IDLE) && cpu_req_i;
    assign want_burst = CAN_BURST && cpu_burst_i && !cpu_we_i;

    // Response decode with err > ack > rty; nothing reaches the CPU during reset.
    assign active          = wbm_cyc_o && !rst;
    assign bus_err         = active && wbm_err_i;
    assign bus_ack         = active && wbm_ack_i && !wbm_err_i;
    assign bus_rty         = active && wbm_rty_i && !wbm_ack_i && !wbm_err_i;
    assign retry_exhausted = (retry_r == RETRY_LIMIT);
    assign adr_match       = cpu_req_i && (cpu_adr_i == wbm_adr_o);

    // Burst beats the CPU is not asking for still complete on the bus, silently.
    assign cpu_ack_o = bus_ack && ((state_r != BURST) || adr_match);
    assign cpu_err_o = bus_err || (bus_rty && retry_exhausted);
    assign cpu_dat_o = cpu_ack_o ? wbm_dat_i : '0;

    // Next state, beat/retry counters and the captured start address.
    always_comb begin
        state_nxt = state_r;
        beat_nxt  = beat_r;
        retry_nxt = retry_r;
        start_nxt = start_r;
        burst_nxt = burst_r;
        case (state_r)
            IDLE: begin
                if (accept) begin
                    start_nxt = cpu_adr_i;
                    beat_nxt  = '0;
                    retry_nxt = '0;
                    burst_nxt = want_burst;
                    state_nxt = want_burst ? BURST : SINGLE;
                end else begin
                    state_nxt = IDLE;
                end
            end
            SINGLE, BURST: begin
                if (bus_err) begin
                    state_nxt = IDLE;
                end else if (bus_ack) begin
                    if ((state_r == SINGLE) || (beat_r == LAST_BEAT)) begin
                        state_nxt = IDLE;
                    end else begin
                        beat_nxt = beat_r + BW'(1);
                    end
                end else if (bus_rty) begin
                    if (retry_exhausted) begin
                        state_nxt = IDLE;
                    end else begin
                        retry_nxt = retry_r + RW'(1);
                        state_nxt = RETRY_WAIT;
                    end
                end else begin
                    state_nxt = state_r;
                end
            end
            RETRY_WAIT: begin
                state_nxt = burst_r ? BURST : SINGLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Bus qualifiers for the cycle after this edge.
    always_comb begin
        cyc_nxt = (state_nxt == SINGLE) || (state_nxt == BURST);
        cti_nxt = CTI_CLASSIC;
        bte_nxt = BTE_LINEAR;
        if (state_nxt == BURST) begin
            cti_nxt = (beat_nxt == LAST_BEAT) ? CTI_EOB : CTI_INCR;
            bte_nxt = BURST_BTE;
        end else begin
            cti_nxt = CTI_CLASSIC;
            bte_nxt = BTE_LINEAR;
        end
    end

    // State, counters and all bus outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= IDLE;
            beat_r    <= '0;
            retry_r   <= '0;
            start_r   <= '0;
            burst_r   <= 1'b0;
            wbm_adr_o <= '0;
            wbm_dat_o <= '0;
            wbm_sel_o <= '0;
            wbm_we_o  <= 1'b0;
            wbm_cyc_o <= 1'b0;
            wbm_stb_o <= 1'b0;
            wbm_cti_o <= CTI_CLASSIC;
            wbm_bte_o <= BTE_LINEAR;
        end else begin
            state_r   <= state_nxt;
            beat_r    <= beat_nxt;
            retry_r   <= retry_nxt;
            start_r   <= start_nxt;
            burst_r   <= burst_nxt;
            wbm_adr_o <= adr_nxt;
            wbm_cyc_o <= cyc_nxt;
            wbm_stb_o <= cyc_nxt;
            wbm_cti_o <= cti_nxt;
            wbm_bte_o <= bte_nxt;
            if (accept) begin
                wbm_dat_o <= cpu_dat_i;
                wbm_sel_o <= cpu_bsel_i;
                wbm_we_o  <= cpu_we_i;
            end
        end
    end

endmodule

// File: tb/tb_or1k_bus_if_wbx.sv
// Self-checking bench: table of CPU accesses with slave behaviour, a response
// scoreboard, plus hand sequences for DW=64 bursts and mid-burst reset.
module tb_or1k_bus_if_wbx;

    localparam int RM = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic        cpu_req_i, cpu_we_i, cpu_burst_i;
    logic [31:0] cpu_adr_i, cpu_dat_i;
    logic [3:0]  cpu_bsel_i;
    logic        cpu_ack_o, cpu_err_o;
    logic [31:0] cpu_dat_o;
    logic [31:0] wbm_adr_o, wbm_dat_o;
    logic [3:0]  wbm_sel_o;
    logic        wbm_we_o, wbm_cyc_o, wbm_stb_o;
    logic [2:0]  wbm_cti_o;
    logic [1:0]  wbm_bte_o;
    logic        wbm_ack_i, wbm_err_i, wbm_rty_i;
    logic [31:0] wbm_dat_i;

    logic        c64_req, c64_we, c64_burst, c64_ack, c64_err;
    logic [31:0] c64_adr;
    logic [63:0] c64_dat, c64_dato;
    logic [7:0]  c64_bsel;
    logic [31:0] w64_adr;
    logic [63:0] w64_dat, w64_dati;
    logic [7:0]  w64_sel;
    logic        w64_we, w64_cyc, w64_stb, w64_ack, w64_err, w64_rty;
    logic [2:0]  w64_cti;
    logic [1:0]  w64_bte;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    or1k_bus_if_wbx #(.DW(32), .BURST_LENGTH(8), .RETRY_MAX(RM)) dut (
        .clk(clk), .rst(rst),
        .cpu_req_i(cpu_req_i), .cpu_adr_i(cpu_adr_i), .cpu_dat_i(cpu_dat_i),
        .cpu_bsel_i(cpu_bsel_i), .cpu_we_i(cpu_we_i), .cpu_burst_i(cpu_burst_i),
        .cpu_ack_o(cpu_ack_o), .cpu_err_o(cpu_err_o), .cpu_dat_o(cpu_dat_o),
        .wbm_adr_o(wbm_adr_o), .wbm_dat_o(wbm_dat_o), .wbm_sel_o(wbm_sel_o),
        .wbm_we_o(wbm_we_o), .wbm_cyc_o(wbm_cyc_o), .wbm_stb_o(wbm_stb_o),
        .wbm_cti_o(wbm_cti_o), .wbm_bte_o(wbm_bte_o),
        .wbm_ack_i(wbm_ack_i), .wbm_err_i(wbm_err_i), .wbm_rty_i(wbm_rty_i),
        .wbm_dat_i(wbm_dat_i)
    );

    or1k_bus_if_wbx #(.DW(64), .BURST_LENGTH(4), .RETRY_MAX(RM)) dut64 (
        .clk(clk), .rst(rst),
        .cpu_req_i(c64_req), .cpu_adr_i(c64_adr), .cpu_dat_i(c64_dat),
        .cpu_bsel_i(c64_bsel), .cpu_we_i(c64_we), .cpu_burst_i(c64_burst),
        .cpu_ack_o(c64_ack), .cpu_err_o(c64_err), .cpu_dat_o(c64_dato),
        .wbm_adr_o(w64_adr), .wbm_dat_o(w64_dat), .wbm_sel_o(w64_sel),
        .wbm_we_o(w64_we), .wbm_cyc_o(w64_cyc), .wbm_stb_o(w64_stb),
        .wbm_cti_o(w64_cti), .wbm_bte_o(w64_bte),
        .wbm_ack_i(w64_ack), .wbm_err_i(w64_err), .wbm_rty_i(w64_rty),
        .wbm_dat_i(w64_dati)
    );

    typedef struct {
        logic        we;
        logic        burst;
        logic [31:0] adr;
        logic [31:0] dat;
        logic [3:0]  sel;
        int          waits;
        int          rty_n;
        int          err_beat;
        int          skip_beat;
        int          exp_acks;
        int          exp_errs;
        int          exp_bus;
    } vec_t;

    typedef struct {
        logic [31:0] adr;
        logic [2:0]  cti;
        logic [1:0]  bte;
        logic        rty;
        logic        err;
        logic        ack_exp;
        logic        err_exp;
        logic        skip;
    } resp_t;

    vec_t  vecs [11];
    resp_t sb [$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] rd32(input logic [31:0] a);
        return a ^ 32'h5A5A_0000 ^ {a[15:0], 16'h0000};
    endfunction

    // Wrap inside a 32-byte block (8 beats of 4 bytes).
    function automatic logic [31:0] exp_adr(input logic [31:0] a, input int b);
        logic [31:0] al;
        logic [31:0] base;
        al   = a & 32'hFFFF_FFFC;
        base = al - (al % 32'd32);
        return base + ((al - base + 32'(b) * 32'd4) % 32'd32);
    endfunction

    function automatic logic [2:0] cti_of(input bit is_b, input int b);
        if (!is_b) return 3'b000;
        return (b == 7) ? 3'b111 : 3'b010;
    endfunction

    task automatic run_vec(input int idx, input vec_t v);
        bit    is_b, prev_cyc, must_idle, term;
        int    nb, n_ack, n_err, n_bus, cyc_cnt, wait_cnt;
        resp_t e;
        is_b = v.burst && !v.we;
        nb   = is_b ? 8 : 1;
        for (int r = 0; r < v.rty_n && r <= RM; r++)
            sb.push_back('{adr: exp_adr(v.adr, 0), cti: cti_of(is_b, 0),
                           bte: is_b ? 2'b10 : 2'b00, rty: 1'b1, err: 1'b0,
                           ack_exp: 1'b0, err_exp: (r == RM), skip: 1'b0});
        if (v.rty_n <= RM) begin
            for (int b = 0; b < nb && (v.err_beat < 0 || b <= v.err_beat); b++)
                sb.push_back('{adr: exp_adr(v.adr, b), cti: cti_of(is_b, b),
                               bte: is_b ? 2'b10 : 2'b00, rty: 1'b0, err: (b == v.err_beat),
                               ack_exp: (b != v.err_beat) && (b != v.skip_beat),
                               err_exp: (b == v.err_beat), skip: (b == v.skip_beat)});
        end
        @(negedge clk);
        cpu_req_i = 1'b1; cpu_adr_i = v.adr; cpu_dat_i = v.dat;
        cpu_bsel_i = v.sel; cpu_we_i = v.we; cpu_burst_i = v.burst;
        n_ack = 0; n_err = 0; n_bus = 0; cyc_cnt = 0; wait_cnt = 0;
        prev_cyc = 1'b0; must_idle = 1'b0; term = 1'b0;
        while ((sb.size() > 0 || must_idle) && cyc_cnt < 100) begin
            @(negedge clk);
            wbm_ack_i = 1'b0; wbm_err_i = 1'b0; wbm_rty_i = 1'b0; wbm_dat_i = '0;
            if (term) cpu_req_i = 1'b0;
            if (cyc_cnt == 0) chk($sformatf("v%0d_lat_cyc", idx), wbm_cyc_o, 1);
            if (must_idle) chk($sformatf("v%0d_gap_cyc", idx), wbm_cyc_o, 0);
            must_idle = 1'b0;
            if (wbm_cyc_o && !prev_cyc) n_bus++;
            prev_cyc = wbm_cyc_o;
            cyc_cnt++;
            if (wbm_cyc_o && wbm_stb_o && sb.size() > 0) begin
                if (wait_cnt < v.waits) begin
                    wait_cnt++;
                end else begin
                    wait_cnt = 0;
                    e = sb.pop_front();
                    chk($sformatf("v%0d_adr", idx), wbm_adr_o, e.adr);
                    chk($sformatf("v%0d_cti", idx), wbm_cti_o, e.cti);
                    chk($sformatf("v%0d_bte", idx), wbm_bte_o, e.bte);
                    chk($sformatf("v%0d_we", idx), wbm_we_o, v.we);
                    chk($sformatf("v%0d_sel", idx), wbm_sel_o, v.sel);
                    if (v.we) chk($sformatf("v%0d_wdat", idx), wbm_dat_o, v.dat);
                    cpu_adr_i = e.skip ? (e.adr ^ 32'h0000_1000) : e.adr;
                    wbm_rty_i = e.rty;
                    wbm_err_i = e.err;
                    wbm_ack_i = !e.rty;
                    wbm_dat_i = rd32(wbm_adr_o);
                    term      = (sb.size() == 0);
                    must_idle = e.rty || term;
                    #1;
                    chk($sformatf("v%0d_cpu_ack", idx), cpu_ack_o, e.ack_exp);
                    chk($sformatf("v%0d_cpu_err", idx), cpu_err_o, e.err_exp);
                    chk($sformatf("v%0d_cpu_dat", idx), cpu_dat_o, e.ack_exp ? rd32(e.adr) : 32'h0);
                    if (cpu_ack_o) n_ack++;
                    if (cpu_err_o) n_err++;
                end
            end
        end
        cpu_req_i = 1'b0;
        wbm_ack_i = 1'b0; wbm_err_i = 1'b0; wbm_rty_i = 1'b0;
        if (sb.size() != 0) begin
            chk($sformatf("v%0d_timeout_left", idx), sb.size(), 0);
            sb.delete();
        end
        chk($sformatf("v%0d_n_acks", idx), n_ack, v.exp_acks);
        chk($sformatf("v%0d_n_errs", idx), n_err, v.exp_errs);
        chk($sformatf("v%0d_n_bus", idx), n_bus, v.exp_bus);
    endtask

    initial begin
        logic [31:0] a64 [4];
        //            we    burst adr           dat            sel    wt rty err skp acks errs bus
        vecs[0]  = '{1'b1, 1'b0, 32'h0000_0100, 32'hDEAD_BEEF, 4'hF,  1, 0, -1, -1, 1, 0, 1};
        vecs[1]  = '{1'b0, 1'b0, 32'h0000_0204, 32'h0000_0000, 4'hF,  0, 0, -1, -1, 1, 0, 1};
        vecs[2]  = '{1'b0, 1'b1, 32'h0000_001C, 32'h0000_0000, 4'hF,  0, 0, -1, -1, 8, 0, 1};
        vecs[3]  = '{1'b0, 1'b1, 32'h0000_001C, 32'h0000_0000, 4'hF,  1, 0, -1, -1, 8, 0, 1};
        vecs[4]  = '{1'b1, 1'b1, 32'h0000_0040, 32'h1234_5678, 4'h3,  0, 0, -1, -1, 1, 0, 1};
        vecs[5]  = '{1'b0, 1'b0, 32'h0000_0300, 32'h0000_0000, 4'hF,  0, 4, -1, -1, 0, 1, 4};
        vecs[6]  = '{1'b1, 1'b0, 32'h0000_0304, 32'hCAFE_F00D, 4'hC,  1, 2, -1, -1, 1, 0, 3};
        vecs[7]  = '{1'b0, 1'b1, 32'h0000_0020, 32'h0000_0000, 4'hF,  0, 0,  3, -1, 3, 1, 1};
        vecs[8]  = '{1'b0, 1'b1, 32'h0000_0008, 32'h0000_0000, 4'hF,  0, 0, -1,  2, 7, 0, 1};
        vecs[9]  = '{1'b1, 1'b0, 32'h0000_0050, 32'h0BAD_F00D, 4'hF,  0, 0,  0, -1, 0, 1, 1};
        vecs[10] = '{1'b0, 1'b1, 32'h0000_0060, 32'h0000_0000, 4'hF,  1, 1, -1, -1, 8, 0, 2};

        rst = 1'b1;
        cpu_req_i = 1'b0; cpu_adr_i = '0; cpu_dat_i = '0; cpu_bsel_i = '0;
        cpu_we_i = 1'b0; cpu_burst_i = 1'b0;
        wbm_ack_i = 1'b0; wbm_err_i = 1'b0; wbm_rty_i = 1'b0; wbm_dat_i = '0;
        c64_req = 1'b0; c64_adr = '0; c64_dat = '0; c64_bsel = '0; c64_we = 1'b0; c64_burst = 1'b0;
        w64_ack = 1'b0; w64_err = 1'b0; w64_rty = 1'b0; w64_dati = '0;
        repeat (3) @(negedge clk);
        chk("rst_ctl", {wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_cti_o, wbm_bte_o, wbm_sel_o, cpu_ack_o, cpu_err_o}, 0);
        chk("rst_adr_dat", {wbm_adr_o, wbm_dat_o}, 0);
        chk("rst_d64", {w64_cyc, w64_stb, w64_adr, w64_cti, w64_bte, w64_sel}, 0);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 11; i++) run_vec(i, vecs[i]);

        // DW=64, 4-beat wrapping burst from 0x18.
        a64 = '{32'h18, 32'h00, 32'h08, 32'h10};
        @(negedge clk);
        c64_req = 1'b1; c64_burst = 1'b1; c64_we = 1'b0; c64_adr = 32'h18; c64_bsel = 8'hFF;
        for (int b = 0; b < 4; b++) begin
            @(negedge clk);
            chk("d64_adr", w64_adr, a64[b]);
            chk("d64_adr_lsb", w64_adr[2:0], 3'b000);
            chk("d64_cti", w64_cti, (b == 3) ? 3'b111 : 3'b010);
            chk("d64_bte", w64_bte, 2'b01);
            chk("d64_sel", w64_sel, 8'hFF);
            c64_adr  = a64[b];
            w64_ack  = 1'b1;
            w64_dati = {rd32(w64_adr), ~rd32(w64_adr)};
            #1;
            chk("d64_ack", c64_ack, 1);
            chk("d64_dat", c64_dato, {rd32(a64[b]), ~rd32(a64[b])});
        end
        @(negedge clk);
        w64_ack = 1'b0; c64_req = 1'b0;
        chk("d64_idle", w64_cyc, 0);

        // Reset in the middle of a burst, with the slave still acking.
        @(negedge clk);
        cpu_req_i = 1'b1; cpu_burst_i = 1'b1; cpu_we_i = 1'b0; cpu_adr_i = 32'h0;
        cpu_bsel_i = 4'hF;
        for (int b = 0; b < 3; b++) begin
            @(negedge clk);
            cpu_adr_i = 32'(b * 4);
            wbm_ack_i = 1'b1;
            wbm_dat_i = rd32(cpu_adr_i);
            #1;
            chk("mr_ack", cpu_ack_o, 1);
        end
        @(negedge clk);
        cpu_adr_i = 32'hC;
        rst = 1'b1;
        #1;
        chk("mr_rst_gate", {cpu_ack_o, cpu_err_o}, 0);
        @(negedge clk);
        chk("mr_outs", {wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_cti_o, wbm_bte_o, wbm_sel_o, cpu_ack_o, cpu_err_o}, 0);
        chk("mr_adr", wbm_adr_o, 0);
        rst = 1'b0; cpu_req_i = 1'b0; wbm_ack_i = 1'b0;
        @(negedge clk);
        chk("mr_after", {wbm_cyc_o, cpu_ack_o, cpu_err_o}, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
